// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Round-robin arbiter that shares the single register-file
//                write port among NUM_REQ writeback sources. It registers the
//                write one cycle after the grant and drops writes to register 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        Stall,
    input  logic [NUM_REQ-1:0]          ReqValid,
    input  logic [NUM_REQ*ADDR_W-1:0]   ReqRegister,
    input  logic [NUM_REQ*DATA_W-1:0]   ReqData,
    output logic [NUM_REQ-1:0]          ReqReady,
    output logic                        RegWrite,
    output logic [ADDR_W-1:0]           WriteRegiter,
    output logic [DATA_W-1:0]           WriteData,
    output logic [2:0]                  GrantId,
    output logic [7:0]                  DropCount
);

    localparam int               PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] c_LAST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        gid_q, gid_d;
    logic [7:0]        drop_q, drop_d;

    logic              w_found;
    logic              w_accept;
    logic [PTR_W-1:0]  w_gnt_idx;
    logic [ADDR_W-1:0] w_sel_reg;
    logic [DATA_W-1:0] w_sel_data;
    int                w_idx;

    // Rotating priority scan: the first valid requester at or after ptr_q wins.
    always_comb begin
        w_found    = 1'b0;
        w_gnt_idx  = '0;
        w_sel_reg  = '0;
        w_sel_data = '0;
        w_idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(ptr_q) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && ReqValid[w_idx]) begin
                w_found    = 1'b1;
                w_gnt_idx  = PTR_W'(w_idx);
                w_sel_reg  = ReqRegister[w_idx*ADDR_W +: ADDR_W];
                w_sel_data = ReqData[w_idx*DATA_W +: DATA_W];
            end
        end
        w_accept = w_found && !Stall && !Reset;
    end

    always_comb begin
        ReqReady = '0;
        if (w_accept) begin
            ReqReady[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        regwrite_d = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        gid_d      = gid_q;
        drop_d     = drop_q;
        if (w_accept) begin
            ptr_d = (w_gnt_idx == c_LAST) ? '0 : w_gnt_idx + PTR_W'(1);
            // A write to $zero still consumes the grant but never reaches the file.
            if (w_sel_reg == '0) begin
                if (drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
            end else begin
                regwrite_d = 1'b1;
                wreg_d     = w_sel_reg;
                wdata_d    = w_sel_data;
                gid_d      = 3'(w_gnt_idx);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ptr_q      <= '0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            gid_q      <= '0;
            drop_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            gid_q      <= gid_d;
            drop_q     <= drop_d;
        end
    end

    assign RegWrite     = regwrite_q;
    assign WriteRegiter = wreg_q;
    assign WriteData    = wdata_q;
    assign GrantId      = gid_q;
    assign DropCount    = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Self-checking bench for regfile_write_arbiter (3 requesters).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [2:0]  valid;
    logic [4:0]  req_reg  [3];
    logic [31:0] req_data [3];
    logic [14:0] reg_bus;
    logic [95:0] data_bus;
    logic [2:0]  ready;
    logic        regwrite;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [2:0]  gid;
    logic [7:0]  dropcount;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_ptr;
    logic        m_regwrite;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    int          m_gid;
    int          m_drop;

    assign reg_bus  = {req_reg[2], req_reg[1], req_reg[0]};
    assign data_bus = {req_data[2], req_data[1], req_data[0]};

    regfile_write_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) dut (
        .Clock        (clk),
        .Reset        (rst),
        .Stall        (stall),
        .ReqValid     (valid),
        .ReqRegister  (reg_bus),
        .ReqData      (data_bus),
        .ReqReady     (ready),
        .RegWrite     (regwrite),
        .WriteRegiter (wreg),
        .WriteData    (wdata),
        .GrantId      (gid),
        .DropCount    (dropcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_grant();
        if (rst || stall) return -1;
        for (int k = 0; k < 3; k++) begin
            if (valid[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        end
        return -1;
    endfunction

    function automatic logic [2:0] model_ready();
        int g;
        g = model_grant();
        return (g < 0) ? 3'b000 : 3'(1 << g);
    endfunction

    // Advance one clock edge and update the reference model to match.
    task automatic tick();
        int g;
        g = model_grant();
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_regwrite = 1'b0; m_wreg = '0; m_wdata = '0; m_gid = 0; m_drop = 0;
        end else begin
            m_regwrite = 1'b0;
            if (g >= 0) begin
                m_ptr = (g + 1) % 3;
                if (req_reg[g] != 5'd0) begin
                    m_regwrite = 1'b1;
                    m_wreg     = req_reg[g];
                    m_wdata    = req_data[g];
                    m_gid      = g;
                end else if (m_drop < 255) begin
                    m_drop = m_drop + 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; valid = 3'b111;
        for (int i = 0; i < 3; i++) begin req_reg[i] = 5'(i + 1); req_data[i] = 32'hA5A5_0000 + i; end
        tick(); tick();
        checks++; if (ready !== 3'b000) begin errors++; $display("FAIL reset_ready got %b exp 000", ready); end
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b exp 0", regwrite); end
        checks++; if (wreg !== 5'd0) begin errors++; $display("FAIL reset_wreg got %0d exp 0", wreg); end
        checks++; if (wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h exp 0", wdata); end
        checks++; if (gid !== 3'd0 || dropcount !== 8'd0) begin errors++; $display("FAIL reset_gid_drop got %0d/%0d exp 0/0", gid, dropcount); end
        rst = 1'b0; valid = 3'b000;
        #1;
    endtask

    task automatic test_single();
        valid = 3'b001; req_reg[0] = 5'd1; req_data[0] = 32'h0000_FFFF;
        #1;
        checks++; if (ready !== 3'b001) begin errors++; $display("FAIL single_ready got %b exp 001", ready); end
        tick();
        valid = 3'b000;
        checks++; if (regwrite !== 1'b1 || wreg !== 5'd1 || wdata !== 32'h0000_FFFF || gid !== 3'd0) begin
            errors++; $display("FAIL single_write got we=%b reg=%0d data=%h id=%0d exp 1/1/0000ffff/0", regwrite, wreg, wdata, gid);
        end
        tick();
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %b exp 0", regwrite); end
    endtask

    task automatic test_round_robin();
        rst = 1'b1; tick(); rst = 1'b0;
        valid = 3'b111;
        for (int i = 0; i < 3; i++) begin req_reg[i] = 5'(i + 1); req_data[i] = 32'h1000_0000 * (i + 1); end
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (ready !== 3'(1 << (i % 3))) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", i, ready, 3'(1 << (i % 3))); end
            tick();
            checks++; if (regwrite !== 1'b1 || gid !== 3'(i % 3) || wreg !== 5'(i % 3 + 1)) begin
                errors++; $display("FAIL rr_write[%0d] got we=%b id=%0d reg=%0d exp 1/%0d/%0d", i, regwrite, gid, wreg, i % 3, i % 3 + 1);
            end
        end
        valid = 3'b000;
        tick();
    endtask

    task automatic test_drop();
        valid = 3'b010; req_reg[1] = 5'd0; req_data[1] = 32'hFFFF_FFFF;
        #1;
        checks++; if (ready !== 3'b010) begin errors++; $display("FAIL drop_ready got %b exp 010", ready); end
        tick();
        checks++; if (regwrite !== 1'b0 || dropcount !== 8'd1) begin
            errors++; $display("FAIL drop_first got we=%b cnt=%0d exp 0/1", regwrite, dropcount);
        end
        checks++; if (wdata !== m_wdata || wreg !== m_wreg || gid !== 3'(m_gid)) begin
            errors++; $display("FAIL drop_hold got reg=%0d data=%h id=%0d exp %0d/%h/%0d", wreg, wdata, gid, m_wreg, m_wdata, m_gid);
        end
        for (int i = 1; i < 300; i++) tick();
        checks++; if (dropcount !== 8'd255) begin errors++; $display("FAIL drop_saturate got %0d exp 255", dropcount); end
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL drop_no_write got %b exp 0", regwrite); end
        valid = 3'b000;
        tick();
    endtask

    task automatic test_stall();
        // After the drop run the pointer sits at requester 2.
        valid = 3'b011; stall = 1'b1;
        req_reg[0] = 5'd7; req_data[0] = 32'h0000_0007;
        req_reg[1] = 5'd8; req_data[1] = 32'h0000_0008;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ready !== 3'b000) begin errors++; $display("FAIL stall_ready[%0d] got %b exp 000", i, ready); end
            tick();
            checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL stall_regwrite[%0d] got %b exp 0", i, regwrite); end
        end
        stall = 1'b0;
        #1;
        checks++; if (ready !== 3'b001) begin errors++; $display("FAIL stall_release_ready got %b exp 001", ready); end
        tick();
        checks++; if (regwrite !== 1'b1 || gid !== 3'd0 || wreg !== 5'd7) begin
            errors++; $display("FAIL stall_release_write got we=%b id=%0d reg=%0d exp 1/0/7", regwrite, gid, wreg);
        end
        valid = 3'b000;
        tick();
    endtask

    task automatic test_reset_mid();
        valid = 3'b100; req_reg[2] = 5'd3; req_data[2] = 32'h8000_0000;
        #1;
        checks++; if (ready !== 3'b100) begin errors++; $display("FAIL rstmid_ready got %b exp 100", ready); end
        tick();
        checks++; if (regwrite !== 1'b1 || wdata !== 32'h8000_0000 || gid !== 3'd2) begin
            errors++; $display("FAIL rstmid_accept got we=%b data=%h id=%0d exp 1/80000000/2", regwrite, wdata, gid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (regwrite !== 1'b0 || wreg !== 5'd0 || wdata !== 32'd0 || gid !== 3'd0 || dropcount !== 8'd0) begin
            errors++; $display("FAIL rstmid_clear got we=%b reg=%0d data=%h id=%0d cnt=%0d exp all 0", regwrite, wreg, wdata, gid, dropcount);
        end
        valid = 3'b110; req_reg[1] = 5'd9; req_data[1] = 32'h0000_0009;
        #1;
        checks++; if (ready !== 3'b010) begin errors++; $display("FAIL rstmid_ptr got %b exp 010", ready); end
        tick();
        checks++; if (regwrite !== 1'b1 || gid !== 3'd1) begin errors++; $display("FAIL rstmid_regrant got we=%b id=%0d exp 1/1", regwrite, gid); end
        valid = 3'b000;
        tick();
    endtask

    task automatic test_random();
        logic [2:0] pend;
        int g;
        pend = 3'b000;
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 99) < 2);
            stall = ($urandom_range(0, 99) < 25);
            for (int i = 0; i < 3; i++) begin
                if (!pend[i]) begin
                    req_reg[i]  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    req_data[i] = $urandom;
                end
                valid[i] = pend[i] ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 1);
            end
            #1;
            checks++; if (ready !== model_ready()) begin errors++; $display("FAIL rand_ready[%0d] got %b exp %b", c, ready, model_ready()); end
            g = model_grant();
            pend = valid;
            if (g >= 0) pend[g] = 1'b0;
            tick();
            checks++; if (regwrite !== m_regwrite || wreg !== m_wreg || wdata !== m_wdata || gid !== 3'(m_gid) || dropcount !== 8'(m_drop)) begin
                errors++; $display("FAIL rand_out[%0d] got we=%b reg=%0d data=%h id=%0d cnt=%0d exp %b/%0d/%h/%0d/%0d",
                    c, regwrite, wreg, wdata, gid, dropcount, m_regwrite, m_wreg, m_wdata, m_gid, m_drop);
            end
        end
        rst = 1'b0; stall = 1'b0; valid = 3'b000;
    endtask

    initial begin
        m_ptr = 0; m_regwrite = 1'b0; m_wreg = '0; m_wdata = '0; m_gid = 0; m_drop = 0;
        rst = 1'b1; stall = 1'b0; valid = 3'b000;
        for (int i = 0; i < 3; i++) begin req_reg[i] = '0; req_data[i] = '0; end
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
